// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment constants, FSM state type and digit-to-segment helpers
package seven_seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  function automatic logic [7:0] hex_to_seg(input logic [3:0] d);
    return SEG_LUT[d];
  endfunction
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/seg_digit_encode.sv
// seg_digit_encode: one 4-bit digit to an active-low segment byte; blanking keeps the DP
module seg_digit_encode
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  assign seg_o = (blank_i ? SEG_BLANK : hex_to_seg(digit_i)) & {~dp_i, 7'h7F};
endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl: binary-to-decimal/hex multi-digit seven-segment driver
// Optional blinking of masked digits when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20
`ifdef SEVEN_SEG_BLINK_EN
  ,parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    hex_mode,
  input  logic                    disp_en,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] segs
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  if (BIN_WIDTH > 4 * NUM_DIGITS || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_param_err
    $error("seven_seg_display_ctrl: BIN_WIDTH exceeds 4*NUM_DIGITS or NUM_DIGITS outside 1..8");
  end

  state_t                  state_q;
  logic [BIN_WIDTH-1:0]    val_q;
  logic [DW-1:0]           bcd_q, bcd_adj, bcd_shift, digits_q;
  logic [CW-1:0]           cnt_q;
  logic                    valid_q, overflow_q, busy_q, done_q, dec_ovf, zero_run;
  logic [NUM_DIGITS-1:0]   lead_zero, blink;
  logic [7:0]              enc [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0] segs_d, segs_q;

  assign dec_ovf = !hex_mode && (64'(value) > DEC_MAX);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end

  assign bcd_shift = DW'({bcd_adj, val_q[BIN_WIDTH-1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (hex_mode || dec_ovf) begin
            state_q    <= COMMIT;
            digits_q   <= DW'(value);
            overflow_q <= dec_ovf;
            valid_q    <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            state_q <= CONV;
            busy_q  <= 1'b1;
            val_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CONV: begin
          bcd_q <= bcd_shift;
          val_q <= val_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(BIN_WIDTH - 1)) begin
            state_q    <= COMMIT;
            busy_q     <= 1'b0;
            digits_q   <= bcd_shift;
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // lead_zero[i]: digit i and every digit above it are zero; digit 0 never qualifies
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (digits_q[4*i+:4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  logic [31:0] div_q;
  logic        phase_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else if (div_q == 32'(BLINK_DIV - 1)) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      div_q <= div_q + 32'd1;
    end
  end
  assign blink = phase_q ? blink_mask : '0;
`else
  assign blink = '0;
`endif

  genvar i;
  for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg_digit_encode u_enc (
      .digit_i (digits_q[4*i+:4]),
      .blank_i (lz_blank && lead_zero[i]),
      .dp_i    (dp_mask[i]),
      .seg_o   (enc[i])
    );
    assign segs_d[8*i+:8] = (!valid_q || !disp_en || blink[i]) ? SEG_BLANK :
                            overflow_q ? (SEG_DASH & {~dp_mask[i], 7'h7F}) : enc[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) segs_q <= '1;
    else        segs_q <= segs_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign segs     = segs_q;
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb_seven_seg_display_ctrl: directed vectors against a value-level display model
module tb_seven_seg_display_ctrl;
  localparam int ND = 6;
  localparam int BW = 20;
  localparam longint DEC_LIM = 1000000;
  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] value = '0;
  logic          hex_mode = 1'b0;
  logic          disp_en = 1'b1;
  logic          lz_blank = 1'b0;
  logic [ND-1:0] dp_mask = '0;
  logic          busy, done, overflow;
  logic [8*ND-1:0] segs;

  int n_vec = 0;
  int n_bad = 0;

  seven_seg_display_ctrl #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
    .disp_en(disp_en), .lz_blank(lz_blank), .dp_mask(dp_mask),
    .busy(busy), .done(done), .overflow(overflow), .segs(segs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Display image from the committed number itself: digit i = (v / base^i) % base
  function automatic logic [8*ND-1:0] model_segs(input longint v, input bit hx, input bit ovf,
      input bit vld, input bit en, input bit lz, input logic [ND-1:0] dp);
    logic [8*ND-1:0] r;
    logic [7:0] s;
    longint base, p;
    r = '1;
    if (!vld || !en) return r;
    base = hx ? 64'd16 : 64'd10;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      if (ovf) s = 8'hBF;
      else if (lz && i > 0 && v < p) s = 8'hFF;
      else s = SEG[int'((v / p) % base)];
      if (dp[i]) s[7] = 1'b0;
      r[8*i+:8] = s;
      p = p * base;
    end
    return r;
  endfunction

  bit e_busy = 0, e_done = 0, m_valid = 0, m_ovf = 0, m_hex = 0, p_hex = 0, m_idle = 0;
  longint m_val = 0, p_val = 0;
  int m_left = 0;
  logic [8*ND-1:0] e_segs = '1;

  task automatic do_commit();
    m_val = p_val;
    m_hex = p_hex;
    m_ovf = !p_hex && p_val >= DEC_LIM;
    m_valid = 1;
    e_done = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e_busy = 0; e_done = 0; m_valid = 0; m_ovf = 0; m_left = 0; e_segs = '1;
    end else begin
      e_segs = model_segs(m_val, m_hex, m_ovf, m_valid, disp_en, lz_blank, dp_mask);
      m_idle = !e_busy && !e_done;
      e_done = 0;
      if (e_busy) begin
        m_left--;
        if (m_left == 0) begin
          e_busy = 0;
          do_commit();
        end
      end else if (m_idle && start) begin
        p_val = longint'(value);
        p_hex = hex_mode;
        if (p_hex || p_val >= DEC_LIM) do_commit();
        else begin
          e_busy = 1;
          m_left = BW;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("segs", 64'(segs), 64'(e_segs));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [BW-1:0] v, input logic h);
    start = 1'b1;
    value = v;
    hex_mode = h;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int k);
    k = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (k == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles", bound);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic count_done(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k, n;
    cyc(3);
    chk("rst_segs", 64'(segs), 64'hFFFFFFFFFFFF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_segs", 64'(segs), 64'hFFFFFFFFFFFF);

    go(20'd123456, 1'b0);
    wait_done(40, k);
    chk("dec_latency", 64'(k), 64'd21);
    chk("dec_123456", 64'(segs), 64'hF9A4B0999282);

    lz_blank = 1'b1;
    go(20'd42, 1'b0);
    wait_done(40, k);
    chk("lz_42", 64'(segs), 64'hFFFFFFFF99A4);
    lz_blank = 1'b0;
    cyc(1);
    chk("nolz_42", 64'(segs), 64'hC0C0C0C099A4);
    lz_blank = 1'b1;
    go(20'd0, 1'b0);
    wait_done(40, k);
    chk("lz_zero", 64'(segs), 64'hFFFFFFFFFFC0);

    go(20'hABCDE, 1'b1);
    wait_done(40, k);
    chk("hex_latency", 64'(k), 64'd1);
    chk("hex_abcde", 64'(segs), 64'hFF8883C6A186);
    dp_mask = 6'b000100;
    cyc(1);
    chk("hex_dp2", 64'(segs), 64'hFF888346A186);
    dp_mask = '0;

    go(20'd1000000, 1'b0);
    wait_done(40, k);
    chk("ovf_latency", 64'(k), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_dash", 64'(segs), 64'hBFBFBFBFBFBF);
    go(20'd7, 1'b0);
    wait_done(40, k);
    chk("ovf_clear", 64'(overflow), 64'd0);
    chk("dec_7", 64'(segs), 64'hFFFFFFFFFFF8);

    disp_en = 1'b0;
    cyc(1);
    chk("disp_off", 64'(segs), 64'hFFFFFFFFFFFF);
    go(20'h88, 1'b1);
    wait_done(40, k);
    chk("disp_off_hold", 64'(segs), 64'hFFFFFFFFFFFF);
    disp_en = 1'b1;
    cyc(1);
    chk("disp_on_88", 64'(segs), 64'hFFFFFFFF8080);

    value = 20'h5;
    hex_mode = 1'b1;
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n++;
      @(posedge clk);
      #1;
      if (i == 2) start = 1'b0;
    end
    chk("b2b_dones", 64'(n), 64'd2);
    chk("b2b_segs", 64'(segs), 64'hFFFFFFFFFF92);

    go(20'd555, 1'b0);
    cyc(4);
    start = 1'b1;
    value = 20'd999;
    hex_mode = 1'b0;
    cyc(1);
    start = 1'b0;
    count_done(30, n);
    chk("busy_start_dones", 64'(n), 64'd1);
    chk("dec_555", 64'(segs), 64'hFFFFFF929292);

    go(20'd123, 1'b0);
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_segs", 64'(segs), 64'hFFFFFFFFFFFF);
    cyc(2);
    rst_n = 1'b1;
    count_done(30, n);
    chk("midrst_dones", 64'(n), 64'd0);
    chk("midrst_blank", 64'(segs), 64'hFFFFFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule
